axi2ahb_rw_sched: RTL and testbench

- Front-end scheduler for the axi2ahb bridge.
- Accepts AXI write-address (AW) and read-address (AR) requests and arbitrates them round-robin onto the bridge's single AHB transfer engine.
- Serves one burst at a time. Generates the per-beat AHB address sequence for FIXED, INCR and WRAP bursts.
- Holds the grant until the engine reports the burst complete (B or last R accepted).

---
 rtl/axi2ahb_rw_sched.sv | 169 ++++++++++++++++
 tb/tb_axi2ahb_rw_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi2ahb_rw_sched.sv
// axi2ahb_rw_sched: front-end scheduler of the axi2ahb bridge.
// Arbitrates AXI AW/AR requests round-robin onto the single AHB transfer engine,
// serves one burst at a time and generates the per-beat address sequence.
//
// Ports:
//   aclk, aresetn                  clock, synchronous active-low reset
//   aw*/ar* (id,addr,len,size,burst,valid) in, awready/arready out
//                                   AXI address channels
//   cmd_valid/cmd_ready            burst command handshake to the engine
//   cmd_write, cmd_id, cmd_len, cmd_size
//                                   latched burst attributes
//   beat_addr, beat_last           current beat address / final-beat flag
//   beat_adv                       engine consumed the current beat address
//   done                           engine finished the burst response
module axi2ahb_rw_sched #(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_ADDR_WIDTH = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ID_WIDTH-1:0]   awid,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [AXI_ID_WIDTH-1:0]   arid,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic                      arvalid,
  output logic                      arready,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic                      cmd_write,
  output logic [AXI_ID_WIDTH-1:0]   cmd_id,
  output logic [7:0]                cmd_len,
  output logic [2:0]                cmd_size,
  output logic [AXI_ADDR_WIDTH-1:0] beat_addr,
  output logic                      beat_last,
  input  logic                      beat_adv,
  input  logic                      done
);

  typedef enum logic [1:0] {StIdle, StCmd, StBeat, StWaitDone} state_e;

  state_e                    state_q;
  logic                      prefer_write_q;
  logic                      write_q;
  logic                      cmd_valid_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic [7:0]                cnt_q;

  logic                      aw_grant;
  logic                      ar_grant;
  logic                      is_last;
  logic [2:0]                eff_size;
  logic                      wrap_ok;
  logic [AXI_ADDR_WIDTH-1:0] bytes;
  logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
  logic [AXI_ADDR_WIDTH-1:0] incr_addr;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;

  // Readies are gated by reset so every output is low while held in reset.
  always_comb begin
    aw_grant = aresetn && (state_q == StIdle) && awvalid && (!arvalid || prefer_write_q);
    ar_grant = aresetn && (state_q == StIdle) && arvalid && (!awvalid || !prefer_write_q);
  end

  assign awready   = aw_grant;
  assign arready   = ar_grant;
  assign cmd_valid = cmd_valid_q;
  assign cmd_write = write_q;
  assign cmd_id    = id_q;
  assign cmd_len   = len_q;
  assign cmd_size  = size_q;
  assign beat_addr = addr_q;
  assign is_last   = (cnt_q == len_q);
  assign beat_last = (state_q == StBeat) && is_last;

  // Next beat address; data path is 32 bits so beat size clamps to 4 bytes.
  always_comb begin
    eff_size  = (size_q > 3'd2) ? 3'd2 : size_q;
    bytes     = AXI_ADDR_WIDTH'(1) << eff_size;
    incr_addr = addr_q + bytes;
    wrap_ok   = (burst_q == 2'b10) &&
                (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
    wrap_mask = ((AXI_ADDR_WIDTH'(len_q) + AXI_ADDR_WIDTH'(1)) << eff_size) - AXI_ADDR_WIDTH'(1);
    if (burst_q == 2'b00) begin
      next_addr = addr_q;
    end else if (wrap_ok) begin
      next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
    end else begin
      // Reserved burst type and non-power-of-two WRAP lengths step like INCR.
      next_addr = incr_addr;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= StIdle;
      prefer_write_q <= 1'b1;
      write_q        <= 1'b0;
      cmd_valid_q    <= 1'b0;
      id_q           <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      size_q         <= '0;
      burst_q        <= '0;
      cnt_q          <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (aw_grant) begin
            id_q           <= awid;
            addr_q         <= awaddr;
            len_q          <= awlen;
            size_q         <= awsize;
            burst_q        <= awburst;
            write_q        <= 1'b1;
            prefer_write_q <= 1'b0;
            cmd_valid_q    <= 1'b1;
            state_q        <= StCmd;
          end else if (ar_grant) begin
            id_q           <= arid;
            addr_q         <= araddr;
            len_q          <= arlen;
            size_q         <= arsize;
            burst_q        <= arburst;
            write_q        <= 1'b0;
            prefer_write_q <= 1'b1;
            cmd_valid_q    <= 1'b1;
            state_q        <= StCmd;
          end
        end
        StCmd: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StBeat;
          end
        end
        StBeat: begin
          if (beat_adv) begin
            if (is_last) begin
              state_q <= StWaitDone;
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= next_addr;
            end
          end
        end
        StWaitDone: begin
          if (done) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi2ahb_rw_sched.sv
module tb_axi2ahb_rw_sched;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [0:0] awid, arid;
  logic [7:0] awaddr, araddr, awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst;
  logic       awvalid, arvalid, awready, arready;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [0:0] cmd_id;
  logic [7:0] cmd_len;
  logic [2:0] cmd_size;
  logic [7:0] beat_addr;
  logic       beat_last, beat_adv, done;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 aclk = ~aclk;

  axi2ahb_rw_sched #(.AXI_ID_WIDTH(1), .AXI_ADDR_WIDTH(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
    .cmd_len(cmd_len), .cmd_size(cmd_size),
    .beat_addr(beat_addr), .beat_last(beat_last), .beat_adv(beat_adv), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requests one burst on AW (wr=1) or AR and checks the grant and command phase.
  // Returns at the negedge where cmd_ready is high; the first beat follows.
  task automatic issue(input bit wr, input logic [0:0] id, input logic [7:0] addr,
                       input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    @(negedge aclk);
    if (wr) begin
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    end else begin
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    end
    #1;
    chk("grant_aw", awready, wr);
    chk("grant_ar", arready, !wr);
    @(negedge aclk);
    awvalid = 1'b0; arvalid = 1'b0; cmd_ready = 1'b1;
    #1;
    chk("cmd_valid", cmd_valid, 1);
    chk("cmd_write", cmd_write, wr);
    chk("cmd_id", cmd_id, id);
    chk("cmd_len", cmd_len, len);
    chk("cmd_size", cmd_size, size);
  endtask

  // Walks the beats in exp_q with beat_adv held high, then completes with done.
  task automatic run_beats();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge aclk);
      cmd_ready = 1'b0; beat_adv = 1'b1;
      #1;
      chk("beat_addr", beat_addr, exp_q[i]);
      chk("beat_last", beat_last, i == exp_q.size() - 1);
    end
    @(negedge aclk);
    beat_adv = 1'b0; done = 1'b1;
    #1;
    chk("wait_last", beat_last, 0);
    chk("wait_cmdv", cmd_valid, 0);
    @(negedge aclk);
    done = 1'b0;
    #1;
  endtask

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    cmd_ready = 1'b0; beat_adv = 1'b0; done = 1'b0;
    repeat (3) @(negedge aclk);
    awvalid = 1'b1; arvalid = 1'b1;
    #1;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_beat_addr", beat_addr, 0);
    chk("rst_beat_last", beat_last, 0);
    chk("rst_cmd_write", cmd_write, 0);
    awvalid = 1'b0; arvalid = 1'b0;

    // Single-beat write at 0x00.
    @(negedge aclk);
    aresetn = 1'b1;
    issue(1'b1, 1'b1, 8'h00, 8'd0, 3'd2, 2'b01);
    @(negedge aclk);
    cmd_ready = 1'b0; beat_adv = 1'b1;
    #1;
    chk("t1_cmdv_drop", cmd_valid, 0);
    chk("t1_addr", beat_addr, 8'h00);
    chk("t1_last", beat_last, 1);
    @(negedge aclk);
    beat_adv = 1'b0; done = 1'b1; awvalid = 1'b1;
    awaddr = 8'h40; awlen = 8'd31; awburst = 2'b00; awsize = 3'd2; awid = 1'b0;
    #1;
    chk("t1_busy_awready", awready, 0);
    chk("t1_wait_last", beat_last, 0);

    // 32-beat FIXED write at 0x40, granted the cycle after done; awvalid stays high.
    @(negedge aclk);
    done = 1'b0;
    #1;
    chk("t2_awready", awready, 1);
    @(negedge aclk);
    cmd_ready = 1'b1;
    #1;
    chk("t2_cmd_valid", cmd_valid, 1);
    chk("t2_cmd_len", cmd_len, 31);
    chk("t2_cmd_write", cmd_write, 1);
    chk("t2_busy_awready", awready, 0);
    for (int i = 0; i < 32; i++) begin
      @(negedge aclk);
      cmd_ready = 1'b0; beat_adv = 1'b1;
      #1;
      chk("t2_addr", beat_addr, 8'h40);
      chk("t2_last", beat_last, i == 31);
      chk("t2_awready", awready, 0);
    end
    @(negedge aclk);
    beat_adv = 1'b0; done = 1'b1;
    #1;
    chk("t2_wait_awready", awready, 0);
    @(negedge aclk);
    done = 1'b0; awvalid = 1'b0;
    #1;

    // WRAP read at 0x38, 4 beats of 4 bytes.
    issue(1'b0, 1'b1, 8'h38, 8'd3, 3'd2, 2'b10);
    exp_q = '{8'h38, 8'h3c, 8'h30, 8'h34};
    run_beats();

    // INCR read crossing the 8-bit address boundary.
    issue(1'b0, 1'b0, 8'hf8, 8'd3, 3'd2, 2'b01);
    exp_q = '{8'hf8, 8'hfc, 8'h00, 8'h04};
    run_beats();

    // SIZE=3 clamps to 4-byte steps.
    issue(1'b1, 1'b0, 8'h10, 8'd1, 3'd3, 2'b01);
    exp_q = '{8'h10, 8'h14};
    run_beats();

    // WRAP with LEN=2 steps like INCR.
    issue(1'b0, 1'b1, 8'h08, 8'd2, 3'd2, 2'b10);
    exp_q = '{8'h08, 8'h0c, 8'h10};
    run_beats();

    // Both channels requesting continuously from reset release: W, R, W, R.
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    awaddr = 8'h20; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    araddr = 8'h24; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("alt_awready", awready, (k % 2) == 0);
      chk("alt_arready", arready, (k % 2) == 1);
      @(negedge aclk);
      cmd_ready = 1'b1;
      #1;
      chk("alt_cmd_write", cmd_write, (k % 2) == 0);
      chk("alt_busy", {awready, arready}, 0);
      @(negedge aclk);
      cmd_ready = 1'b0; beat_adv = 1'b1;
      #1;
      chk("alt_addr", beat_addr, ((k % 2) == 0) ? 8'h20 : 8'h24);
      chk("alt_busy_beat", {awready, arready}, 0);
      @(negedge aclk);
      beat_adv = 1'b0; done = 1'b1;
      #1;
      chk("alt_busy_wait", {awready, arready}, 0);
      @(negedge aclk);
      done = 1'b0;
      #1;
    end
    awvalid = 1'b0; arvalid = 1'b0;

    // Reset in the middle of a 16-beat burst, with a write and a read pending.
    issue(1'b1, 1'b1, 8'h80, 8'd15, 3'd2, 2'b01);
    exp_q = '{8'h80, 8'h84, 8'h88};
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      cmd_ready = 1'b0; beat_adv = 1'b1;
      #1;
      chk("rb_addr", beat_addr, exp_q[i]);
    end
    @(negedge aclk);
    beat_adv = 1'b0; aresetn = 1'b0; awvalid = 1'b1; arvalid = 1'b1;
    awaddr = 8'h00; awlen = 8'd0;
    @(negedge aclk);
    #1;
    chk("rb_cmd_valid", cmd_valid, 0);
    chk("rb_beat_addr", beat_addr, 0);
    chk("rb_beat_last", beat_last, 0);
    chk("rb_cmd_len", cmd_len, 0);
    chk("rb_cmd_write", cmd_write, 0);
    chk("rb_cmd_id", cmd_id, 0);
    chk("rb_readies", {awready, arready}, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("rb_awready", awready, 1);
    chk("rb_arready", arready, 0);
    @(negedge aclk);
    awvalid = 1'b0; arvalid = 1'b0;
    #1;
    chk("rb_cmd_write_after", cmd_write, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
